// File: rtl/shift_pipe.sv
// shift_pipe: pipelined barrel shifter/rotator.
// One registered level per shift-amount bit. Level k moves the operand by 2^k
// positions when bit k of the shift amount is set. Valid/ready handshakes
// are on both sides, and a sideband tag travels with each operation.
// The pipeline only advances as a whole, so in_ready depends on the last
// stage alone and there is no combinational path from in_valid to in_ready.
module shift_pipe #(
   parameter  int WIDTH   = 16,            // operand width, power of two, >= 2
   parameter  int TAG_W   = 4,             // sideband tag width
   localparam int SHAMT_W = $clog2(WIDTH)  // shift-amount width and pipeline depth
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [1:0]         in_op,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [TAG_W-1:0]   out_tag,
   output logic               busy
);

   typedef enum logic [1:0] {
      OP_ROL = 2'b00,
      OP_SLL = 2'b01,
      OP_ROR = 2'b10,
      OP_SRL = 2'b11
   } op_e;

   localparam int LAST = SHAMT_W - 1;

   // Stage registers, index k = stage Sk.
   logic [SHAMT_W-1:0]              v_q;
   logic [SHAMT_W-1:0][WIDTH-1:0]   d_q;
   logic [SHAMT_W-1:0][1:0]         op_q;
   logic [SHAMT_W-1:0][TAG_W-1:0]   tag_q;
   // The whole shift amount rides along; bits below k are dead by stage k
   // and are trimmed away by synthesis.
   logic [SHAMT_W-1:0][SHAMT_W-1:0] sh_q;

   // What each stage would load on the next advance.
   logic [SHAMT_W-1:0]              src_v;
   logic [SHAMT_W-1:0][WIDTH-1:0]   src_d;
   logic [SHAMT_W-1:0][1:0]         src_op;
   logic [SHAMT_W-1:0][TAG_W-1:0]   src_tag;
   logic [SHAMT_W-1:0][SHAMT_W-1:0] src_sh;
   logic [SHAMT_W-1:0][WIDTH-1:0]   nxt_d;

   logic stall;
   logic accept;

   // One level of shift/rotate by a fixed amount n (0 < n < WIDTH).
   function automatic logic [WIDTH-1:0] level_shift(input logic [WIDTH-1:0] x,
                                                    input op_e              op,
                                                    input int               n);
      logic [WIDTH-1:0] r;
      case (op)
         OP_ROL:  r = (x << n) | (x >> (WIDTH - n));
         OP_SLL:  r = x << n;
         OP_ROR:  r = (x >> n) | (x << (WIDTH - n));
         default: r = x >> n;
      endcase
      return r;
   endfunction

   assign stall  = v_q[LAST] && !out_ready;
   assign in_ready = !stall;
   assign accept = in_valid && in_ready;

   // Per-stage input selection and the shift of that stage's power of two.
   for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
      if (k == 0) begin : g_head
         assign src_v[k]   = accept;
         assign src_d[k]   = in_data;
         assign src_op[k]  = in_op;
         assign src_tag[k] = in_tag;
         assign src_sh[k]  = in_shamt;
      end else begin : g_link
         assign src_v[k]   = v_q[k-1];
         assign src_d[k]   = d_q[k-1];
         assign src_op[k]  = op_q[k-1];
         assign src_tag[k] = tag_q[k-1];
         assign src_sh[k]  = sh_q[k-1];
      end
      assign nxt_d[k] = src_sh[k][k] ? level_shift(src_d[k], op_e'(src_op[k]), 1 << k)
                                     : src_d[k];
   end

   // Pipeline registers: the whole pipe advances together or holds on stall;
   // payload only loads behind a valid so bubbles leave it untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the payload arrays are reset too, so out_data/out_tag read 0
         // after reset instead of whatever was in flight.
         v_q   <= '0;
         d_q   <= '0;
         op_q  <= '0;
         tag_q <= '0;
         sh_q  <= '0;
      end else if (!stall) begin
         // NOTE: non-blocking assignments let every stage sample the previous
         // stage's old value, which is what makes this a shift register.
         v_q <= src_v;
         for (int k = 0; k < SHAMT_W; k++) begin
            if (src_v[k]) begin
               d_q[k]   <= nxt_d[k];
               op_q[k]  <= src_op[k];
               tag_q[k] <= src_tag[k];
               sh_q[k]  <= src_sh[k];
            end
         end
      end
   end

   assign out_valid = v_q[LAST];
   assign out_data  = d_q[LAST];
   assign out_tag   = tag_q[LAST];
   assign busy      = |v_q;

endmodule
